// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Brief    : RV32I load/store funct3 codes, LSU state encoding, request check.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam logic [2:0] c_F3_LB  = 3'b000;
    localparam logic [2:0] c_F3_LH  = 3'b001;
    localparam logic [2:0] c_F3_LW  = 3'b010;
    localparam logic [2:0] c_F3_LBU = 3'b100;
    localparam logic [2:0] c_F3_LHU = 3'b101;

    localparam logic [2:0] c_F3_SB  = 3'b000;
    localparam logic [2:0] c_F3_SH  = 3'b001;
    localparam logic [2:0] c_F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } lsu_state_t;

    // funct3[1:0] encodes the access size for every legal load and store.
    function automatic logic access_error(input logic       write,
                                          input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
        logic illegal;
        logic misaligned;
        if (write)
            illegal = !(funct3 inside {c_F3_SB, c_F3_SH, c_F3_SW});
        else
            illegal = funct3 inside {3'b011, 3'b110, 3'b111};
        case (funct3[1:0])
            2'b01:   misaligned = addr_lo[0];
            2'b10:   misaligned = (addr_lo != 2'b00);
            default: misaligned = 1'b0;
        endcase
        return illegal | misaligned;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit_if
// Brief    : Controller request/response and memory bus signals of the LSU.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_access_unit_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    // master: the controller plus memory environment around the unit
    modport master (
        output req_valid, req_write, req_addr, req_funct3, req_wdata,
        output mem_ack, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_funct3, req_wdata,
        input  mem_ack, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

endinterface
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_align
// Brief    : Combinational store lane replication/strobes and load extension.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_align
    import riscv_pkg::*;
(
    input  wire logic [2:0]  i_st_funct3,
    input  wire logic [1:0]  i_st_addr_lo,
    input  wire logic [31:0] i_st_wdata,
    output logic      [31:0] o_st_wdata,
    output logic      [3:0]  o_st_wstrb,
    input  wire logic [2:0]  i_ld_funct3,
    input  wire logic [1:0]  i_ld_addr_lo,
    input  wire logic [31:0] i_ld_word,
    output logic      [31:0] o_ld_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_st_wdata = i_st_wdata;
        o_st_wstrb = 4'b1111;
        case (i_st_funct3)
            c_F3_SB: begin
                o_st_wdata = {4{i_st_wdata[7:0]}};
                o_st_wstrb = 4'b0001 << i_st_addr_lo;
            end
            c_F3_SH: begin
                o_st_wdata = {2{i_st_wdata[15:0]}};
                o_st_wstrb = i_st_addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (i_ld_addr_lo)
            2'd0:    w_byte = i_ld_word[7:0];
            2'd1:    w_byte = i_ld_word[15:8];
            2'd2:    w_byte = i_ld_word[23:16];
            default: w_byte = i_ld_word[31:24];
        endcase
        w_half = i_ld_addr_lo[1] ? i_ld_word[31:16] : i_ld_word[15:0];
    end

    always_comb begin
        case (i_ld_funct3)
            c_F3_LB:  o_ld_result = {{24{w_byte[7]}}, w_byte};
            c_F3_LH:  o_ld_result = {{16{w_half[15]}}, w_half};
            c_F3_LBU: o_ld_result = {24'd0, w_byte};
            c_F3_LHU: o_ld_result = {16'd0, w_half};
            default:  o_ld_result = i_ld_word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Brief    : RV32I load/store unit: one outstanding word access with timeout.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  wire logic        clk,
    input  wire logic        reset,
    mem_access_unit_if.slave bus
);

    localparam int                c_CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_t         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_write;
    logic [2:0]         r_funct3;
    logic [1:0]         r_addr_lo;

    logic               r_req_ready;
    logic               r_resp_valid;
    logic               r_resp_err;
    logic [31:0]        r_resp_rdata;
    logic               r_mem_req;
    logic               r_mem_we;
    logic [31:0]        r_mem_addr;
    logic [31:0]        r_mem_wdata;
    logic [3:0]         r_mem_wstrb;

    logic               w_req_err;
    logic [31:0]        w_st_wdata;
    logic [3:0]         w_st_wstrb;
    logic [31:0]        w_ld_rdata;

    assign w_req_err = access_error(bus.req_write, bus.req_funct3, bus.req_addr[1:0]);

    // Store path works on the incoming request, load path on the latched one.
    lsu_align u_align (
        .i_st_funct3  (bus.req_funct3),
        .i_st_addr_lo (bus.req_addr[1:0]),
        .i_st_wdata   (bus.req_wdata),
        .o_st_wdata   (w_st_wdata),
        .o_st_wstrb   (w_st_wstrb),
        .i_ld_funct3  (r_funct3),
        .i_ld_addr_lo (r_addr_lo),
        .i_ld_word    (bus.mem_rdata),
        .o_ld_result  (w_ld_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_write      <= 1'b0;
            r_funct3     <= '0;
            r_addr_lo    <= '0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_wstrb  <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_write     <= bus.req_write;
                        r_funct3    <= bus.req_funct3;
                        r_addr_lo   <= bus.req_addr[1:0];
                        r_req_ready <= 1'b0;
                        if (w_req_err) begin
                            r_state      <= ST_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= '0;
                        end else begin
                            r_state     <= ST_ACCESS;
                            r_cnt       <= '0;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= bus.req_write;
                            r_mem_addr  <= {bus.req_addr[31:2], 2'b00};
                            r_mem_wdata <= bus.req_write ? w_st_wdata : '0;
                            r_mem_wstrb <= bus.req_write ? w_st_wstrb : 4'b0000;
                        end
                    end
                end
                ST_ACCESS: begin
                    // An ack on the final counted cycle still wins over the timeout.
                    if (bus.mem_ack || (r_cnt == c_CNT_LAST)) begin
                        r_state      <= ST_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= ~bus.mem_ack;
                        r_resp_rdata <= (bus.mem_ack && !r_write) ? w_ld_rdata : '0;
                        r_mem_req    <= 1'b0;
                        r_mem_we     <= 1'b0;
                        r_mem_addr   <= '0;
                        r_mem_wdata  <= '0;
                        r_mem_wstrb  <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                    r_resp_err  <= 1'b0;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_err   = r_resp_err;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.mem_req    = r_mem_req;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.mem_wstrb  = r_mem_wstrb;

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, SHALL set the maximum cycles mem_req waits for mem_ack before error.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-003 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-004 req_valid  input  1  SHALL indicate a load/store request from the controller.
REQ-005 req_ready  output  1  SHALL indicate the unit can accept a request.
REQ-006 req_write  input  1  SHALL select store (1) or load (0).
REQ-007 req_addr  input  32  SHALL be the byte address.
REQ-008 req_funct3  input  3  SHALL be the RV32I access size/sign code.
REQ-009 req_wdata  input  32  SHALL be the unaligned store data (rs2).
REQ-010 resp_valid  output  1  SHALL pulse one cycle on completion.
REQ-011 resp_rdata  output  32  SHALL be the extended load result, 0 for stores/errors.
REQ-012 resp_err  output  1  SHALL flag misaligned, illegal funct3, or timeout; valid only with resp_valid.
REQ-013 mem_req  output  1  SHALL request a bus access.
REQ-014 mem_we  output  1  SHALL indicate a bus write.
REQ-015 mem_addr  output  32  SHALL be the word address (low 2 bits zero).
REQ-016 mem_wdata  output  32  SHALL be the lane-aligned store data.
REQ-017 mem_wstrb  output  4  SHALL be the byte-lane write strobes (0000 on reads).
REQ-018 mem_ack  input  1  SHALL be the bus completion; mem_rdata sampled in the same cycle.
REQ-019 mem_rdata  input  32  SHALL be the word read data.

Function
REQ-020 FSM states SHALL be IDLE, ACCESS, RESP; req_ready=1 only in IDLE.
REQ-021 IDLE with req_valid SHALL latch addr/funct3/write/wdata; legal requests go to ACCESS, errors go to RESP with resp_err=1 and no mem_req.
REQ-022 Misaligned SHALL mean halfword with addr[0]=1 or word with addr[1:0]!=0; illegal SHALL mean load funct3 011/110/111 or store funct3 other than 000/001/010.
REQ-023 ACCESS SHALL hold mem_req=1 and all mem_* outputs stable until mem_ack=1, then go to RESP.
REQ-024 Minimum latency: accept at cycle 0, mem_req at cycle 1, ack at cycle 1, resp_valid at cycle 2.
REQ-025 A timeout counter SHALL clear on entering ACCESS; after TIMEOUT_CYCLES cycles without ack, the unit SHALL drop mem_req, enter RESP, and set resp_err=1.
REQ-026 RESP SHALL assert resp_valid for exactly one cycle and return to IDLE; a req_valid during RESP SHALL be ignored.
REQ-027 Stores: sb SHALL replicate byte x4 with wstrb=0001<<addr[1:0]; sh SHALL replicate the halfword x2 with wstrb=0011<<(2*addr[1]); sw SHALL use wstrb=1111.
REQ-028 Loads: lb/lh SHALL sign-extend, lbu/lhu SHALL zero-extend the lane selected by latched addr[1:0]; lw SHALL pass the word.
REQ-029 resp_rdata SHALL be registered from mem_rdata at the ack cycle.
REQ-030 mem_ack outside ACCESS SHALL be ignored.

Reset
REQ-031 reset SHALL force IDLE, clear the timeout counter, and drive req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_req=0, mem_we=0, mem_wstrb=0, mem_addr=0, mem_wdata=0.
REQ-032 Reset during ACCESS SHALL drop mem_req the next cycle and produce no resp_valid.

Structure
REQ-033 Funct3 load/store constants and the state enum SHALL live in the shared riscv_pkg package.
REQ-034 Lane alignment and extension SHALL be a combinational sub-module, lsu_align.

Verification
REQ-035 sw addr=0x100 wdata=0xDEADBEEF, ack at cycle 1 -> mem_addr=0x100, wstrb=1111, resp_valid at cycle 2, resp_err=0.
REQ-036 sb addr=0x103 wdata=0x000000A5 -> mem_addr=0x100, wdata=0xA5A5A5A5, wstrb=1000.
REQ-037 lb addr=0x102 with mem_rdata=0x12F0_3456 -> resp_rdata=0xFFFFFFF0; lbu at the same address -> 0x000000F0.
REQ-038 lw addr=0x101 -> no mem_req, resp_valid one cycle later, resp_err=1, resp_rdata=0.
REQ-039 lh addr=0x200 with ack withheld -> mem_req held 16 cycles, then dropped, resp_err=1.
REQ-040 reset asserted in cycle 2 of ACCESS -> mem_req=0 next cycle, no resp_valid, req_ready=1.
